// File: rtl/ov7670_frame_writer.sv
// ov7670_frame_writer: turns the RGB565 pixel stream into addressed frame-buffer write requests
// through a small FIFO. Define OV7670_DECIMATE_EN for 2:1 decimation in both axes.
module ov7670_frame_writer #(
    parameter int unsigned H_RES      = 640,
    parameter int unsigned V_RES      = 480,
    parameter int unsigned ADDR_W     = 19,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic              pclk,
    input  logic              reset,
    input  logic              pix_valid,
    input  logic [15:0]       pix_data,
    input  logic              frame_start,
    input  logic              line_end,
    input  logic              wr_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [15:0]       wr_data,
    output logic              frame_done,
    output logic              overflow,
    output logic [7:0]        frame_count
);

    localparam int unsigned XW = $clog2(H_RES) + 1;
    localparam int unsigned YW = $clog2(V_RES) + 1;
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
`ifdef OV7670_DECIMATE_EN
    localparam int unsigned LINE_STEP = H_RES / 2;
`else
    localparam int unsigned LINE_STEP = H_RES;
`endif

    typedef enum logic [1:0] {
        StIdle,
        StActive,
        StDrop
    } state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [15:0]       data;
        logic              last;
    } entry_t;

    state_e            state_q, state_d;
    logic [XW-1:0]     x_q, x_d, cur_x;
    logic [YW-1:0]     y_q, y_d, cur_y;
    logic [ADDR_W-1:0] base_q, base_d, cur_base;

    entry_t            stg_q, new_entry;
    logic              stg_vld_q, stg_vld_d;

    entry_t            mem [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              overflow_q;
    logic [7:0]        frame_count_q;

    logic run, x_in_range, y_in_range, keep, is_last, take, line_adv;
    logic full, empty, push, pop, overrun;
    entry_t head;

    // frame_start overrides the registered position so the coincident pixel lands at (0,0)
    assign run      = frame_start || (state_q == StActive);
    assign cur_x    = frame_start ? '0 : x_q;
    assign cur_y    = frame_start ? '0 : y_q;
    assign cur_base = frame_start ? '0 : base_q;

    assign x_in_range = cur_x < XW'(H_RES);
    assign y_in_range = cur_y < YW'(V_RES);

`ifdef OV7670_DECIMATE_EN
    assign keep     = x_in_range && y_in_range && !cur_x[0] && !cur_y[0];
    assign is_last  = (cur_x == XW'(H_RES - 2)) && (cur_y == YW'(V_RES - 2));
    assign line_adv = cur_y[0];
`else
    assign keep     = x_in_range && y_in_range;
    assign is_last  = (cur_x == XW'(H_RES - 1)) && (cur_y == YW'(V_RES - 1));
    assign line_adv = 1'b1;
`endif

    assign take = run && pix_valid && keep;

    always_comb begin
        new_entry      = '0;
`ifdef OV7670_DECIMATE_EN
        new_entry.addr = cur_base + ADDR_W'(cur_x >> 1);
`else
        new_entry.addr = cur_base + ADDR_W'(cur_x);
`endif
        new_entry.data = pix_data;
        new_entry.last = is_last;
    end

    // FIFO status and handshake
    assign full    = (cnt_q == CW'(FIFO_DEPTH));
    assign empty   = (cnt_q == '0);
    assign head    = mem[rd_ptr_q];
    assign pop     = !empty && wr_ready;
    assign push    = stg_vld_q && (!full || pop);
    assign overrun = stg_vld_q && full && !pop;

    // An overrun also kills the pixel arriving alongside it, unless it starts a new frame
    assign stg_vld_d = take && !(overrun && !frame_start);

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        base_d  = base_q;
        if (frame_start) begin
            state_d = StActive;
            x_d     = '0;
            y_d     = '0;
            base_d  = '0;
        end
        if (run) begin
            // x and y saturate one past the last valid index so range checks never wrap
            if (pix_valid && x_in_range) begin
                x_d = cur_x + XW'(1);
            end
            if (line_end) begin
                x_d = '0;
                if (y_in_range) begin
                    y_d = cur_y + YW'(1);
                    if (line_adv) begin
                        base_d = cur_base + ADDR_W'(LINE_STEP);
                    end
                end
            end
            if (take && is_last) begin
                state_d = StIdle;
            end
        end
        if (overrun && (state_q == StActive) && !frame_start) begin
            state_d = StDrop;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (reset) begin
            state_q       <= StIdle;
            x_q           <= '0;
            y_q           <= '0;
            base_q        <= '0;
            stg_vld_q     <= 1'b0;
            stg_q         <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            cnt_q         <= '0;
            overflow_q    <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            base_q    <= base_d;
            stg_vld_q <= stg_vld_d;
            if (take) begin
                stg_q <= new_entry;
            end
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            cnt_q <= cnt_d;
            if (overrun) begin
                overflow_q <= 1'b1;
            end
            if (pop && head.last) begin
                frame_count_q <= frame_count_q + 8'd1;
            end
        end
    end

    // Storage needs no reset: occupancy is tracked by cnt_q
    always_ff @(posedge pclk) begin
        if (push) begin
            mem[wr_ptr_q] <= stg_q;
        end
    end

    assign wr_en       = !empty;
    assign wr_addr     = empty ? '0 : head.addr;
    assign wr_data     = empty ? '0 : head.data;
    assign frame_done  = pop && head.last;
    assign overflow    = overflow_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_ov7670_frame_writer.sv
// Directed bench for ov7670_frame_writer with H_RES=4 and a 4-entry FIFO.
module tb_ov7670_frame_writer;
`ifdef OV7670_DECIMATE_EN
    localparam int unsigned TB_V = 4;
`else
    localparam int unsigned TB_V = 2;
`endif

    logic        pclk = 1'b0;
    logic        reset = 1'b1;
    logic        pix_valid = 1'b0;
    logic [15:0] pix_data = '0;
    logic        frame_start = 1'b0;
    logic        line_end = 1'b0;
    logic        wr_ready = 1'b0;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic        frame_done;
    logic        overflow;
    logic [7:0]  frame_count;

    int errors = 0;
    int checks = 0;
    int log_addr[$];
    int log_data[$];
    bit log_done[$];
    int done_n = 0;

    always #5 pclk = ~pclk;

    ov7670_frame_writer #(
        .H_RES     (4),
        .V_RES     (TB_V),
        .ADDR_W    (4),
        .FIFO_DEPTH(4)
    ) dut (
        .pclk       (pclk),
        .reset      (reset),
        .pix_valid  (pix_valid),
        .pix_data   (pix_data),
        .frame_start(frame_start),
        .line_end   (line_end),
        .wr_ready   (wr_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .frame_done (frame_done),
        .overflow   (overflow),
        .frame_count(frame_count)
    );

    // Record every handshake mid-cycle, where inputs and outputs are settled
    always @(negedge pclk) begin
        if (!reset) begin
            if (wr_en && wr_ready) begin
                log_addr.push_back(int'(wr_addr));
                log_data.push_back(int'(wr_data));
                log_done.push_back(frame_done);
            end
            if (frame_done) done_n++;
        end
    end

    task automatic cyc();
        @(posedge pclk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc();
    endtask

    task automatic px(input int d, input logic fs, input logic le);
        pix_valid   = 1'b1;
        pix_data    = 16'(d);
        frame_start = fs;
        line_end    = le;
        cyc();
        pix_valid   = 1'b0;
        frame_start = 1'b0;
        line_end    = 1'b0;
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
        log_done.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        wr_ready = 1'b0;
        idle(3);
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got %b want 0", wr_en); end
        checks++; if (wr_addr !== 4'd0) begin errors++; $display("FAIL reset_wr_addr got %0d want 0", wr_addr); end
        checks++; if (wr_data !== 16'd0) begin errors++; $display("FAIL reset_wr_data got %h want 0", wr_data); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got %b want 0", frame_done); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", overflow); end
        checks++; if (frame_count !== 8'd0) begin errors++; $display("FAIL reset_frame_count got %0d want 0", frame_count); end
        reset = 1'b0;
        idle(1);
    endtask

    task automatic test_single_frame();
        int d0, ga, gd;
        bit gf;
        wr_ready = 1'b1;
        clear_log();
        d0 = done_n;
        px(1, 1'b1, 1'b0);
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL latency_early got wr_en=%b want 0", wr_en); end
        px(2, 1'b0, 1'b0);
        checks++; if (wr_en !== 1'b1 || wr_addr !== 4'd0 || wr_data !== 16'd1) begin
            errors++; $display("FAIL latency_first got en=%b addr=%0d data=%h want 1/0/0001", wr_en, wr_addr, wr_data);
        end
        for (int i = 3; i <= 8; i++) px(i, 1'b0, (i == 4 || i == 8));
        idle(4);
        checks++; if (log_addr.size() != 8) begin errors++; $display("FAIL single_count got %0d want 8", log_addr.size()); end
        for (int i = 0; i < 8; i++) begin
            ga = (i < log_addr.size()) ? log_addr[i] : -1;
            gd = (i < log_data.size()) ? log_data[i] : -1;
            gf = (i < log_done.size()) ? log_done[i] : 1'b0;
            checks++; if (ga != i || gd != i + 1 || gf != (i == 7)) begin
                errors++; $display("FAIL single_write%0d got addr=%0d data=%0h done=%b want %0d/%0h/%b", i, ga, gd, gf, i, i + 1, (i == 7));
            end
        end
        checks++; if (done_n - d0 != 1) begin errors++; $display("FAIL single_done_pulses got %0d want 1", done_n - d0); end
        checks++; if (frame_count !== 8'd1) begin errors++; $display("FAIL single_frame_count got %0d want 1", frame_count); end
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL single_drained got wr_en=%b want 0", wr_en); end
    endtask

    task automatic test_backpressure();
        int ga, gd;
        wr_ready = 1'b1;
        clear_log();
        px(1, 1'b1, 1'b0);
        wr_ready = 1'b0;
        idle(1);
        for (int k = 0; k < 6; k++) begin
            checks++; if (wr_en !== 1'b1 || wr_addr !== 4'd0 || wr_data !== 16'd1 || log_addr.size() != 0) begin
                errors++; $display("FAIL stall_hold%0d got en=%b addr=%0d data=%h writes=%0d want 1/0/0001/0", k, wr_en, wr_addr, wr_data, log_addr.size());
            end
            if (k < 5) begin
                if (k % 2 == 0) px(k / 2 + 2, 1'b0, (k == 4));
                else idle(1);
            end
        end
        wr_ready = 1'b1;
        for (int i = 5; i <= 8; i++) px(i, 1'b0, (i == 8));
        idle(6);
        checks++; if (log_addr.size() != 8) begin errors++; $display("FAIL bp_count got %0d want 8", log_addr.size()); end
        for (int i = 0; i < 8; i++) begin
            ga = (i < log_addr.size()) ? log_addr[i] : -1;
            gd = (i < log_data.size()) ? log_data[i] : -1;
            checks++; if (ga != i || gd != i + 1) begin
                errors++; $display("FAIL bp_write%0d got addr=%0d data=%0h want %0d/%0h", i, ga, gd, i, i + 1);
            end
        end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL bp_overflow got %b want 0", overflow); end
        checks++; if (frame_count !== 8'd2) begin errors++; $display("FAIL bp_frame_count got %0d want 2", frame_count); end
    endtask

    task automatic test_overrun();
        int d0, ga, gd;
        wr_ready = 1'b0;
        clear_log();
        d0 = done_n;
        for (int i = 1; i <= 4; i++) px(i, (i == 1), (i == 4));
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovr_not_yet got %b want 0", overflow); end
        px(5, 1'b0, 1'b0);
        px(6, 1'b0, 1'b0);
        idle(1);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovr_flag got %b want 1", overflow); end
        checks++; if (wr_en !== 1'b1 || wr_addr !== 4'd0 || wr_data !== 16'd1) begin
            errors++; $display("FAIL ovr_head got en=%b addr=%0d data=%h want 1/0/0001", wr_en, wr_addr, wr_data);
        end
        wr_ready = 1'b1;
        idle(8);
        checks++; if (log_addr.size() != 4) begin errors++; $display("FAIL ovr_count got %0d want 4", log_addr.size()); end
        for (int i = 0; i < 4; i++) begin
            ga = (i < log_addr.size()) ? log_addr[i] : -1;
            gd = (i < log_data.size()) ? log_data[i] : -1;
            checks++; if (ga != i || gd != i + 1) begin
                errors++; $display("FAIL ovr_write%0d got addr=%0d data=%0h want %0d/%0h", i, ga, gd, i, i + 1);
            end
        end
        checks++; if (done_n != d0) begin errors++; $display("FAIL ovr_no_done got %0d pulses want 0", done_n - d0); end
        checks++; if (frame_count !== 8'd2) begin errors++; $display("FAIL ovr_frame_count got %0d want 2", frame_count); end
        clear_log();
        for (int i = 0; i < 8; i++) px(16'h11 + i, (i == 0), (i == 3 || i == 7));
        idle(4);
        checks++; if (log_addr.size() != 8) begin errors++; $display("FAIL ovr_next_count got %0d want 8", log_addr.size()); end
        for (int i = 0; i < 8; i++) begin
            ga = (i < log_addr.size()) ? log_addr[i] : -1;
            gd = (i < log_data.size()) ? log_data[i] : -1;
            checks++; if (ga != i || gd != 16'h11 + i) begin
                errors++; $display("FAIL ovr_next_write%0d got addr=%0d data=%0h want %0d/%0h", i, ga, gd, i, 16'h11 + i);
            end
        end
        checks++; if (frame_count !== 8'd3) begin errors++; $display("FAIL ovr_next_frame_count got %0d want 3", frame_count); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovr_sticky got %b want 1", overflow); end
    endtask

    task automatic test_restart();
        int d0, ga, gd;
        bit gf;
        int ea[10] = '{0, 1, 0, 1, 2, 3, 4, 5, 6, 7};
        int ed[10] = '{16'h31, 16'h32, 16'h40, 16'h41, 16'h42, 16'h43, 16'h44, 16'h45, 16'h46, 16'h47};
        wr_ready = 1'b1;
        clear_log();
        d0 = done_n;
        px(16'h31, 1'b1, 1'b0);
        px(16'h32, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) px(16'h40 + i, (i == 0), (i == 3 || i == 7));
        idle(4);
        checks++; if (log_addr.size() != 10) begin errors++; $display("FAIL restart_count got %0d want 10", log_addr.size()); end
        for (int i = 0; i < 10; i++) begin
            ga = (i < log_addr.size()) ? log_addr[i] : -1;
            gd = (i < log_data.size()) ? log_data[i] : -1;
            gf = (i < log_done.size()) ? log_done[i] : 1'b0;
            checks++; if (ga != ea[i] || gd != ed[i] || gf != (i == 9)) begin
                errors++; $display("FAIL restart_write%0d got addr=%0d data=%0h done=%b want %0d/%0h/%b", i, ga, gd, gf, ea[i], ed[i], (i == 9));
            end
        end
        checks++; if (done_n - d0 != 1) begin errors++; $display("FAIL restart_done_pulses got %0d want 1", done_n - d0); end
        checks++; if (frame_count !== 8'd4) begin errors++; $display("FAIL restart_frame_count got %0d want 4", frame_count); end
    endtask

    task automatic test_out_of_range();
        int ga, gd;
        bit gf;
        int ed[8] = '{16'h51, 16'h52, 16'h53, 16'h54, 16'h61, 16'h62, 16'h63, 16'h64};
        wr_ready = 1'b1;
        clear_log();
        for (int i = 0; i < 6; i++) px(16'h51 + i, (i == 0), (i == 5));
        for (int i = 0; i < 4; i++) px(16'h61 + i, 1'b0, (i == 3));
        idle(4);
        checks++; if (log_addr.size() != 8) begin errors++; $display("FAIL oor_count got %0d want 8", log_addr.size()); end
        for (int i = 0; i < 8; i++) begin
            ga = (i < log_addr.size()) ? log_addr[i] : -1;
            gd = (i < log_data.size()) ? log_data[i] : -1;
            gf = (i < log_done.size()) ? log_done[i] : 1'b0;
            checks++; if (ga != i || gd != ed[i] || gf != (i == 7)) begin
                errors++; $display("FAIL oor_write%0d got addr=%0d data=%0h done=%b want %0d/%0h/%b", i, ga, gd, gf, i, ed[i], (i == 7));
            end
        end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL oor_overflow got %b want 1", overflow); end
        checks++; if (frame_count !== 8'd5) begin errors++; $display("FAIL oor_frame_count got %0d want 5", frame_count); end
    endtask

    task automatic test_reset_mid();
        wr_ready = 1'b0;
        px(16'h71, 1'b1, 1'b0);
        px(16'h72, 1'b0, 1'b0);
        px(16'h73, 1'b0, 1'b0);
        reset = 1'b1;
        cyc();
        checks++; if (wr_en !== 1'b0 || wr_addr !== 4'd0 || wr_data !== 16'd0) begin
            errors++; $display("FAIL midreset_wr got en=%b addr=%0d data=%h want 0/0/0000", wr_en, wr_addr, wr_data);
        end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL midreset_overflow got %b want 0", overflow); end
        checks++; if (frame_count !== 8'd0) begin errors++; $display("FAIL midreset_frame_count got %0d want 0", frame_count); end
        reset = 1'b0;
        wr_ready = 1'b1;
        clear_log();
        px(16'h74, 1'b0, 1'b0);
        px(16'h75, 1'b0, 1'b1);
        idle(4);
        checks++; if (log_addr.size() != 0) begin errors++; $display("FAIL midreset_idle_writes got %0d want 0", log_addr.size()); end
    endtask

    task automatic test_decimate();
        int d0, ga, gd;
        bit gf;
        int ed[4] = '{1, 3, 9, 11};
        wr_ready = 1'b1;
        clear_log();
        d0 = done_n;
        for (int i = 0; i < 16; i++) px(i + 1, (i == 0), (i % 4 == 3));
        idle(4);
        checks++; if (log_addr.size() != 4) begin errors++; $display("FAIL dec_count got %0d want 4", log_addr.size()); end
        for (int i = 0; i < 4; i++) begin
            ga = (i < log_addr.size()) ? log_addr[i] : -1;
            gd = (i < log_data.size()) ? log_data[i] : -1;
            gf = (i < log_done.size()) ? log_done[i] : 1'b0;
            checks++; if (ga != i || gd != ed[i] || gf != (i == 3)) begin
                errors++; $display("FAIL dec_write%0d got addr=%0d data=%0h done=%b want %0d/%0h/%b", i, ga, gd, gf, i, ed[i], (i == 3));
            end
        end
        checks++; if (done_n - d0 != 1) begin errors++; $display("FAIL dec_done_pulses got %0d want 1", done_n - d0); end
        checks++; if (frame_count !== 8'd1) begin errors++; $display("FAIL dec_frame_count got %0d want 1", frame_count); end
    endtask

    initial begin
        test_reset();
`ifdef OV7670_DECIMATE_EN
        test_decimate();
`else
        test_single_frame();
        test_backpressure();
        test_overrun();
        test_restart();
        test_out_of_range();
        test_reset_mid();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ov7670_frame_writer.md
# ov7670_frame_writer

Downstream stage of `ov7670_capture`: consumes the assembled 16-bit RGB565 pixel stream and turns it into addressed frame-buffer write requests. A small FIFO absorbs memory backpressure, because the camera side cannot stall. Everything runs in the `pclk` domain. Output feeds the frame-buffer memory port.

## Interface
- `H_RES`, 640, active pixels per line
- `V_RES`, 480, active lines per frame
- `ADDR_W`, 19, write address width (must hold H_RES*V_RES-1)
- `FIFO_DEPTH`, 16, entries; power of two, ≥4
- Clock/reset: one clock, `pclk`. Reset is `reset`, synchronous and active-high.
- `pclk`  in  1  pixel clock, all logic on rising edge
- `reset`  in  1  synchronous active-high reset
- `pix_valid`  in  1  pixel present on `pix_data` this cycle
- `pix_data`  in  16  RGB565 pixel
- `frame_start`  in  1  pulse, coincident with first pixel of a frame
- `line_end`  in  1  pulse, coincident with last pixel of a line
- `wr_ready`  in  1  memory accepts write this cycle
- `wr_en`  out  1  write request valid
- `wr_addr`  out  ADDR_W  linear pixel address
- `wr_data`  out  16  pixel to write
- `frame_done`  out  1  one-cycle pulse, last pixel of frame written
- `overflow`  out  1  sticky, FIFO overrun occurred
- `frame_count`  out  8  completed frames, wraps 255→0

## Operation
- States:
  - IDLE: discard everything until `frame_start`.
  - ACTIVE: accept pixels.
  - DROP: discard pixels until next `frame_start`.
- Transitions:
  - `frame_start` in any state → ACTIVE, x=0, y=0, line_base=0. That pixel is processed as (0,0).
  - Overrun in ACTIVE → DROP.
  - Last pixel of frame accepted → IDLE.
- Counters:
  - Each accepted `pix_valid` in ACTIVE increments x.
  - `line_end` sets x=0, y+=1, line_base+=H_RES.
  - Address = line_base + x; no multiplier.
- Bounds: pixels with x≥H_RES or y≥V_RES are discarded silently. They do not raise overflow.
- Overrun: push attempted while FIFO full and no pop in the same cycle. Consequences:
  - `overflow` is set; only `reset` clears it.
  - The pixel is dropped and the state goes to DROP.
  - Queued entries still drain.
- FIFO entry is {addr, data, last}. `last` = (x==H_RES-1 && y==V_RES-1).
- `frame_done` pulses on the write handshake (`wr_en && wr_ready`) of an entry with `last` set.
  - `frame_count` increments in the same cycle.
- Mid-frame `frame_start`: abandons the current frame, with no `frame_done`. The FIFO is not flushed; old entries drain to their original addresses.

## Timing
- Reset values:
  - Outputs: `wr_en`=0, `wr_addr`=0, `wr_data`=0, `frame_done`=0, `overflow`=0, `frame_count`=0.
  - Internal: state IDLE, FIFO empty, x=y=0.
- Latency: pixel accepted at edge N appears on `wr_*` with `wr_en`=1 after edge N+1, when the FIFO was empty.
- Handshake:
  - `wr_en` = FIFO non-empty.
  - Transfer occurs when `wr_en && wr_ready`.
  - `wr_addr`/`wr_data` are held stable while `wr_en && !wr_ready`.
  - Back-to-back transfers sustain 1 per cycle.
- Full boundary: simultaneous push and pop while full is legal, with no overrun. Occupancy stays FIFO_DEPTH.
- Empty boundary: push and pop never occur on the same entry in the same cycle. A push to an empty FIFO becomes visible the next cycle.
- `reset` mid-frame: everything returns to reset values on the next edge, and FIFO contents are lost.
- Counter widths: x, y are `clog2` of H_RES/V_RES plus 1 bit, so out-of-range detection never wraps.

## Configuration
- `OV7670_DECIMATE_EN` defined: 2:1 decimation in both axes.
  - Only pixels with even x and even y are pushed.
  - Addresses are compacted as (y/2)*(H_RES/2) + x/2, and line_base advances by H_RES/2 every second line.
  - `last` = (x==H_RES-2 && y==V_RES-2).
  - Frame holds H_RES*V_RES/4 pixels.
- Undefined: every in-range pixel is written at full resolution, as described above.

## Test plan
- Single frame, no backpressure (H_RES=4, V_RES=2, undecimated): send 8 pixels 0x0001..0x0008 with `wr_ready`=1 → writes to addr 0..7 in order, data matching; `frame_done` pulses once on the addr 7 handshake; `frame_count`=1.
- Backpressure (same frame, `wr_ready` low 5 cycles after first push) → `wr_addr`/`wr_data` held at 0/0x0001 throughout the stall; all 8 writes complete in order; no overflow.
- Overrun (FIFO_DEPTH=4, `wr_ready`=0, 6 pixels) → `overflow`=1 on the 5th pixel; only addrs 0..3 are written after `wr_ready` rises; no `frame_done`. The next `frame_start` frame completes normally with `overflow` still 1.
- Mid-frame restart: `frame_start` on pixel 3 of a frame → that pixel is written to addr 0; no `frame_done` for the abandoned frame.
- Out-of-range: a line with 6 pixels before `line_end` (H_RES=4) → pixels 5 and 6 produce no write; the next line starts at addr 4.
- With `OV7670_DECIMATE_EN` (H_RES=4, V_RES=4): 16 pixels → 4 writes to addr 0..3, carrying the pixels at (0,0), (2,0), (0,2), (2,2); `frame_done` fires on addr 3.
